// File: rtl/dest_filter_rr.sv
`default_nettype none
// ============================================================================
// Module      : dest_filter_rr
// Description : Per-destination filter and merge stage. Keeps packets from
//               every source whose rx field equals DEST, buffers them in a
//               per-source FIFO and round-robin merges them onto a single
//               registered valid/ready output.
//               Optional feature macro: FILTER_DROP_CNT_EN adds the
//               saturating drop_cnt output and its counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_filter_rr #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEST       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [PORT_NUB*(1+2*$clog2(PORT_NUB)+DATA_WIDTH)-1:0] port_in,
    output logic [PORT_NUB-1:0]                                   in_ready,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [2*$clog2(PORT_NUB)+DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(PORT_NUB)-1:0]                           out_src
`ifdef FILTER_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]                                  drop_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_SEL_W = $clog2(PORT_NUB);
    localparam int c_OUT_W = 2*c_SEL_W + DATA_WIDTH;
    localparam int c_IN_W  = 1 + c_OUT_W;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_SEL_W-1:0] c_DEST    = c_SEL_W'(DEST);
    localparam logic [c_SEL_W-1:0] c_LAST    = c_SEL_W'(PORT_NUB-1);
    localparam logic [c_SEL_W-1:0] c_SEL_ONE = c_SEL_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // Per-source status shared between the FIFOs and the arbiter
    // ------------------------------------------------------------------------
    logic [PORT_NUB-1:0] w_match;
    logic [PORT_NUB-1:0] w_ready;
    logic [PORT_NUB-1:0] w_nonempty;
    logic [PORT_NUB-1:0] w_pop;
    logic [c_OUT_W-1:0]  w_head [PORT_NUB];

    // Arbiter / output register state
    logic [c_SEL_W-1:0]  r_rr_ptr;
    logic [c_SEL_W-1:0]  w_grant;
    logic [c_SEL_W-1:0]  w_rr_next;
    logic                w_any;
    logic                w_load;
    logic                r_out_valid;
    logic [c_OUT_W-1:0]  r_out_data;
    logic [c_SEL_W-1:0]  r_out_src;

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

    // ------------------------------------------------------------------------
    // Per-source match filter and FIFO
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_src
        logic [c_IN_W-1:0]  w_slice;
        logic               w_valid;
        logic [c_SEL_W-1:0] w_rx;
        logic [c_OUT_W-1:0] w_pkt;
        logic               w_push;

        logic [c_OUT_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_CNT_W-1:0] r_count;

        // Slice layout is {valid, rx, tx, data}; the stored packet drops valid
        assign w_slice = port_in[gi*c_IN_W +: c_IN_W];
        assign w_valid = w_slice[c_IN_W-1];
        assign w_rx    = w_slice[c_OUT_W-1 -: c_SEL_W];
        assign w_pkt   = w_slice[c_OUT_W-1:0];

        // Ready ignores a same-cycle pop so it is a pure function of state
        assign w_match[gi]    = w_valid && (w_rx == c_DEST);
        assign w_ready[gi]    = (r_count < c_FULL);
        assign w_push         = w_match[gi] && w_ready[gi];
        assign w_nonempty[gi] = (r_count != '0);
        assign w_head[gi]     = r_mem[r_rd_ptr];

        // Storage array is not reset: occupancy is tracked by r_count alone
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_pkt;
            end
        end

        // Pointer and occupancy bookkeeping; pointers wrap naturally
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop[gi]})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin grant: first non-empty FIFO starting at r_rr_ptr
    // ------------------------------------------------------------------------
    always_comb begin : p_arb
        int v_idx;
        w_grant = '0;
        w_any   = 1'b0;
        v_idx   = 0;
        for (int k = 0; k < PORT_NUB; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % PORT_NUB;
            if (!w_any && w_nonempty[v_idx]) begin
                w_any   = 1'b1;
                w_grant = v_idx[c_SEL_W-1:0];
            end
        end
    end

    // Output register accepts a new packet when empty or being consumed
    assign w_load    = !r_out_valid || out_ready;
    assign w_rr_next = (w_grant == c_LAST) ? '0 : (w_grant + c_SEL_ONE);

    // One-hot pop toward the granted FIFO when the output register loads
    always_comb begin
        w_pop = '0;
        if (w_load && w_any) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    // Output register and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_head[w_grant];
                r_out_src  <= w_grant;
                r_rr_ptr   <= w_rr_next;
            end
        end
    end

`ifdef FILTER_DROP_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating drop counter: sums matches refused by a full FIFO
    // ------------------------------------------------------------------------
    localparam logic [CNT_WIDTH:0]   c_DROP_ONE = (CNT_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0] c_DROP_MAX = '1;

    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] w_drop_next;

    assign drop_cnt = r_drop_cnt;

    // Add one per dropping source; clamp if the sum passes the maximum
    always_comb begin : p_drop
        logic [CNT_WIDTH:0] v_sum;
        v_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < PORT_NUB; i++) begin
            if (w_match[i] && !w_ready[i]) begin
                v_sum = v_sum + c_DROP_ONE;
            end
        end
        w_drop_next = v_sum[CNT_WIDTH] ? c_DROP_MAX : v_sum[CNT_WIDTH-1:0];
    end

    // Drop counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dest_filter_rr.sv
`default_nettype none
module tb_dest_filter_rr;

    localparam int PN = 4;
    localparam int DW = 8;
    localparam int DST = 2;
    localparam int FD = 4;
    localparam int CW = 8;
    localparam int SW = 2;
    localparam int IW = 1 + 2*SW + DW;
    localparam int OW = 2*SW + DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PN*IW-1:0] port_in = '0;
    logic [PN-1:0]    in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OW-1:0]    out_data;
    logic [SW-1:0]    out_src;
`ifdef FILTER_DROP_CNT_EN
    logic [CW-1:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source plus the output register view
    logic [OW-1:0] mq [PN][$];
    bit            m_ov;
    logic [OW-1:0] m_od;
    int            m_os;
    int            m_rr;
    int            m_drop;

    always #5 clk = ~clk;

    dest_filter_rr #(
        .PORT_NUB  (PN),
        .DATA_WIDTH(DW),
        .DEST      (DST),
        .FIFO_DEPTH(FD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port_in  (port_in),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
`ifdef FILTER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    function automatic logic [IW-1:0] mk(input bit v, input int rx, input int tx, input int d);
        return {v, 2'(rx), 2'(tx), 8'(d)};
    endfunction

    function automatic logic [OW-1:0] pk(input int rx, input int tx, input int d);
        return {2'(rx), 2'(tx), 8'(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PN; i++) mq[i].delete();
        m_ov = 1'b0;
        m_od = '0;
        m_os = 0;
        m_rr = 0;
        m_drop = 0;
    endtask

    // Advance the model across one rising edge given the inputs of that cycle
    task automatic model_step(input logic [PN*IW-1:0] pin, input bit ordy);
        bit            rdy [PN];
        bit            found;
        int            g;
        int            idx;
        logic [IW-1:0] s;
        for (int i = 0; i < PN; i++) rdy[i] = (mq[i].size() < FD);
        if (!m_ov || ordy) begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < PN; k++) begin
                idx = (m_rr + k) % PN;
                if (!found && mq[idx].size() > 0) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            if (found) begin
                m_od = mq[g].pop_front();
                m_os = g;
                m_ov = 1'b1;
                m_rr = (g + 1) % PN;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < PN; i++) begin
            s = pin[i*IW +: IW];
            if (s[IW-1] && int'(s[OW-1 -: SW]) == DST) begin
                if (rdy[i]) mq[i].push_back(s[OW-1:0]);
                else if (m_drop < (1 << CW) - 1) m_drop++;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        logic [PN-1:0] r;
        for (int i = 0; i < PN; i++) r[i] = (mq[i].size() < FD);
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, "/out_data"}, 32'(out_data), 32'(m_od));
        chk({tag, "/out_src"}, 32'(out_src), 32'(m_os));
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(r));
`ifdef FILTER_DROP_CNT_EN
        chk({tag, "/drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    task automatic tick(input logic [PN*IW-1:0] pin, input bit ordy, input string tag);
        port_in = pin;
        out_ready = ordy;
        model_step(pin, ordy);
        @(posedge clk);
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [PN*IW-1:0] pin;
        bit               v;
        int               rx;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_data", 32'(out_data), 32'd0);
        chk("rst/out_src", 32'(out_src), 32'd0);
        chk("rst/in_ready", 32'(in_ready), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet latency from source 1
        pin = '0;
        pin[1*IW +: IW] = mk(1, 2, 1, 'hA5);
        tick(pin, 1'b1, "t1a");
        chk("t1/lat0", 32'(out_valid), 32'd0);
        tick('0, 1'b1, "t1b");
        chk("t1/valid", 32'(out_valid), 32'd1);
        chk("t1/data", 32'(out_data), 32'h9A5);
        chk("t1/src", 32'(out_src), 32'd1);
        tick('0, 1'b1, "t1c");
        chk("t1/empty", 32'(out_valid), 32'd0);

        // Non-matching packet is filtered and never counted
        pin = '0;
        pin[0 +: IW] = mk(1, 3, 0, 'h11);
        tick(pin, 1'b1, "t2a");
        chk("t2/ready", 32'(in_ready), 32'hF);
        tick('0, 1'b1, "t2b");
        chk("t2/valid", 32'(out_valid), 32'd0);
`ifdef FILTER_DROP_CNT_EN
        chk("t2/drop", 32'(drop_cnt), 32'd0);
`endif

        // Three simultaneous sources from rr_ptr=0
        sync_reset();
        pin = '0;
        pin[0*IW +: IW] = mk(1, 2, 0, 'h40);
        pin[1*IW +: IW] = mk(1, 2, 1, 'h41);
        pin[3*IW +: IW] = mk(1, 2, 3, 'h43);
        tick(pin, 1'b1, "t3a");
        tick('0, 1'b1, "t3b");
        chk("t3/src0", 32'(out_src), 32'd0);
        tick('0, 1'b1, "t3c");
        chk("t3/src1", 32'(out_src), 32'd1);
        tick('0, 1'b1, "t3d");
        chk("t3/src3", 32'(out_src), 32'd3);
        chk("t3/data3", 32'(out_data), 32'(pk(2, 3, 'h43)));
        tick('0, 1'b1, "t3e");
        chk("t3/idle", 32'(out_valid), 32'd0);
        // rr_ptr wrapped to 0: source 0 wins over source 3
        pin = '0;
        pin[0*IW +: IW] = mk(1, 2, 0, 'h50);
        pin[3*IW +: IW] = mk(1, 2, 3, 'h53);
        tick(pin, 1'b1, "t3f");
        tick('0, 1'b1, "t3g");
        chk("t3/wrap0", 32'(out_src), 32'd0);
        tick('0, 1'b1, "t3h");
        chk("t3/wrap3", 32'(out_src), 32'd3);
        tick('0, 1'b1, "t3i");

        // Backpressure: fill output register and FIFO 2
        for (int k = 0; k < 5; k++) begin
            pin = '0;
            pin[2*IW +: IW] = mk(1, 2, 2, 'h30 + k);
            tick(pin, 1'b0, "t4fill");
        end
        chk("t4/full", 32'(in_ready[2]), 32'd0);
        chk("t4/held", 32'(out_data), 32'(pk(2, 2, 'h30)));
        pin = '0;
        pin[2*IW +: IW] = mk(1, 2, 2, 'h35);
        tick(pin, 1'b0, "t4drop");
`ifdef FILTER_DROP_CNT_EN
        chk("t4/drop", 32'(drop_cnt), 32'd1);
`endif
        // Held stable for three cycles of out_ready=0
        for (int k = 0; k < 2; k++) begin
            tick('0, 1'b0, "t5hold");
            chk("t5/data", 32'(out_data), 32'(pk(2, 2, 'h30)));
            chk("t5/src", 32'(out_src), 32'd2);
        end
        // Drain: one pop per handshake, original order
        for (int k = 1; k < 5; k++) begin
            tick('0, 1'b1, "t4drain");
            chk("t4/order", 32'(out_data), 32'(pk(2, 2, 'h30 + k)));
            if (k == 1) chk("t5/onepop", 32'(in_ready[2]), 32'd1);
        end
        tick('0, 1'b1, "t4end");
        chk("t4/empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while data is buffered and out_valid is high
        pin = '0;
        pin[0*IW +: IW] = mk(1, 2, 0, 'h61);
        pin[2*IW +: IW] = mk(1, 2, 2, 'h62);
        tick(pin, 1'b0, "t6a");
        tick(pin, 1'b0, "t6b");
        chk("t6/valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6/valid", 32'(out_valid), 32'd0);
        chk("t6/data", 32'(out_data), 32'd0);
        chk("t6/src", 32'(out_src), 32'd0);
        chk("t6/ready", 32'(in_ready), 32'hF);
        port_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick('0, 1'b1, "t6post");
            chk("t6/nostale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pin = '0;
            for (int i = 0; i < PN; i++) begin
                v = (($urandom % 100) < 45);
                rx = ($urandom % 2 == 0) ? 2 : int'($urandom % 4);
                pin[i*IW +: IW] = mk(v, rx, int'($urandom % 4), int'($urandom % 256));
            end
            tick(pin, (($urandom % 100) < 60), "rand");
            if (n == 1500) sync_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
